// File: rtl/efgh_pkg.sv
// rtl/efgh_pkg.sv - shared widths and SHA-256 round helper functions
package efgh_pkg;

  localparam int WORD_W = 32;
  localparam int EFG_W  = 3 * WORD_W;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t sigma1(input word_t e);
    word_t r6, r11, r25;
    r6  = {e[5:0],  e[31:6]};
    r11 = {e[10:0], e[31:11]};
    r25 = {e[24:0], e[31:25]};
    return r6 ^ r11 ^ r25;
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

endpackage

// File: rtl/sha256_t1_partial.sv
// rtl/sha256_t1_partial.sv - combinational partial T1 = Sigma1(e) + Ch(e,f,g) + agwk
module sha256_t1_partial
  import efgh_pkg::*;
(
  input  logic [WORD_W-1:0] e,
  input  logic [WORD_W-1:0] f,
  input  logic [WORD_W-1:0] g,
  input  logic [WORD_W-1:0] agwk,
  output logic [WORD_W-1:0] sum
);

  // Carries past bit 31 fall off naturally in the 32-bit result.
  always_comb begin
    sum = sigma1(e) + ch(e, f, g) + agwk;
  end

endmodule

// File: rtl/efgh.sv
// rtl/efgh.sv - registered SHA-256 e/f/g shift and partial T1 stage
module efgh
  import efgh_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [EFG_W-1:0]  din,
  input  logic [WORD_W-1:0] agwk,
  output logic [EFG_W-1:0]  dout,
  output logic [WORD_W-1:0] hout
);

  logic [WORD_W-1:0] t1_sum;

  sha256_t1_partial u_t1 (
    .e    (din[95:64]),
    .f    (din[63:32]),
    .g    (din[31:0]),
    .agwk (agwk),
    .sum  (t1_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      hout <= '0;
    end else begin
      dout <= din;
      hout <= t1_sum;
    end
  end

endmodule

// File: tb/tb_efgh.sv
// tb/tb_efgh.sv - directed self-checking bench for efgh
module tb_efgh;

  logic        clk;
  logic        rst;
  logic [95:0] din;
  logic [31:0] agwk;
  logic [95:0] dout;
  logic [31:0] hout;

  int errors = 0;
  int checks = 0;

  localparam logic [95:0] DIN_A  = 96'h238956e3_af5e1cba_a8a8881c;
  localparam logic [31:0] AGWK_A = 32'h87bb7a3d;
  localparam logic [31:0] H_A    = 32'hc7253cdb;
  localparam logic [95:0] DIN_B  = 96'h9ebad54f_85b1c84a_72f4312b;
  localparam logic [31:0] AGWK_B = 32'h1b1914cf;
  localparam logic [31:0] H_B    = 32'hcaf190f9;

  efgh dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .agwk (agwk),
    .dout (dout),
    .hout (hout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one input pair, clock it in, and check outputs just after the edge.
  task automatic step(input string tag, input logic [95:0] d, input logic [31:0] a,
                      input logic [31:0] exp_h);
    din  = d;
    agwk = a;
    @(posedge clk);
    #1;
    check({tag, "_hout"}, {64'h0, hout}, {64'h0, exp_h});
    check({tag, "_dout"}, dout, d);
  endtask

  initial begin
    rst  = 1'b0;
    din  = DIN_A;
    agwk = AGWK_A;
    @(posedge clk);
    #1;
    check("rst_dout", dout, 96'h0);
    check("rst_hout", {64'h0, hout}, 96'h0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_no_edge_hout", {64'h0, hout}, 96'h0);

    step("vec_a", DIN_A, AGWK_A, H_A);
    step("vec_b", DIN_B, AGWK_B, H_B);

    // Alternating A/B; also confirm new inputs do not reach outputs before the edge
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        din = DIN_A; agwk = AGWK_A;
        #1;
        check("hold_before_edge", {64'h0, hout}, {64'h0, (i == 0) ? H_B : H_B});
        step("alt_a", DIN_A, AGWK_A, H_A);
      end else begin
        step("alt_b", DIN_B, AGWK_B, H_B);
      end
    end

    // Asynchronous reset between edges while A is registered
    step("pre_rst_a", DIN_A, AGWK_A, H_A);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_dout", dout, 96'h0);
    check("async_rst_hout", {64'h0, hout}, 96'h0);
    #1;
    rst = 1'b1;
    din = DIN_B;
    agwk = AGWK_B;
    #1;
    check("post_rst_still_zero", {64'h0, hout}, 96'h0);
    step("post_rst_b", DIN_B, AGWK_B, H_B);

    step("all_ones", {96{1'b1}}, 32'hffffffff, 32'hfffffffd);
    step("all_zeros", 96'h0, 32'h0, 32'h00000000);
    step("repeat_a1", DIN_A, AGWK_A, H_A);
    step("repeat_a2", DIN_A, AGWK_A, H_A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/efgh.md
EFGH -- requirements
Module: efgh

Interface
REQ-001 The module SHALL have no parameters; word width is fixed at 32 bits (SHA-256).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 din  input  96  packed {e, f, g} working words of the current SHA-256 round; e = din[95:64], f = din[63:32], g = din[31:0].
REQ-005 agwk  input  32  precomputed partial sum h + K[t] + W[t] for the current round, mod 2^32.
REQ-006 dout  output  96  registered {e, f, g} = next-round {f, g, h} words.
REQ-007 hout  output  32  registered partial T1 = Sigma1(e) + Ch(e,f,g) + agwk, mod 2^32.

Function
REQ-008 Sigma1(e) SHALL equal ROTR6(e) XOR ROTR11(e) XOR ROTR25(e), with 32-bit rotate-right.
REQ-009 Ch(e,f,g) SHALL equal (e AND f) XOR ((NOT e) AND g), bitwise.
REQ-010 hout SHALL be computed as Sigma1(e) + Ch(e,f,g) + agwk, truncated to 32 bits; all carries out of bit 31 are discarded.
REQ-011 dout SHALL be din captured unchanged, so that {e,f,g} shift down to {f,g,h} for the next round.
REQ-012 Latency SHALL be exactly one clock: values on din/agwk sampled at rising edge N appear on dout/hout after edge N and hold until edge N+1.
REQ-013 The block SHALL be fully pipelined: a new independent din/agwk pair is accepted every cycle with no handshake, stall or enable.
REQ-014 Inputs SHALL be combinationally unrelated to outputs; no path from din/agwk to dout/hout bypasses the output registers.
REQ-015 The block SHALL hold no state other than the dout and hout registers; back-to-back identical or alternating inputs produce identical per-cycle results.

Reset
REQ-016 While rst = 0, dout SHALL be 96'h0 and hout SHALL be 32'h0, regardless of clk.
REQ-017 Reset assertion SHALL take effect immediately (asynchronously); a result in flight is discarded.
REQ-018 After rst returns to 1, the first rising edge SHALL capture the current din/agwk normally.

Structure
REQ-019 A shared package SHALL hold the word width constant (32), the packed {e,f,g} width (96), and pure functions sigma1 and ch.
REQ-020 One combinational sub-module, sha256_t1_partial (inputs e,f,g,agwk; output 32-bit sum), is natural; efgh instantiates it and adds the output registers.
REQ-021 The three-operand addition MAY use a carry-save stage followed by one 32-bit adder; results SHALL be bit-identical to REQ-010.

Verification
REQ-022 Vector A: din=238956e3_af5e1cba_a8a8881c, agwk=87bb7a3d -> next cycle hout=c7253cdb, dout=238956e3_af5e1cba_a8a8881c (intermediates Sigma1=944125e0, Ch=ab289cbe; sum overflows bit 31).
REQ-023 Vector B: din=9ebad54f_85b1c84a_72f4312b, agwk=1b1914cf -> next cycle hout=caf190f9, dout equal to din.
REQ-024 Alternate A,B,A,B on consecutive edges -> hout c7253cdb, caf190f9, c7253cdb, caf190f9 on consecutive cycles, each one cycle after its input.
REQ-025 Drive rst=0 asynchronously between edges while A is registered -> dout=0, hout=0 immediately; release, apply B -> hout=caf190f9 one edge later.
REQ-026 Boundary: din all-ones, agwk=ffffffff -> Sigma1=ffffffff, Ch=ffffffff, hout=fffffffd (wrap mod 2^32); din all-zeros, agwk=0 -> hout=00000000.
